// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Turns a 1-bit spike train back into numbers. Two results are produced:
//   - rate: rising-edge count over a programmable window of window+1 cycles
//   - isi:  the interval, in cycles, between the two most recent rising edges
//
// Ports
//   clk         in            system clock, all state on the rising edge
//   rst_n       in            asynchronous active-low reset
//   en          in            decoder enable; low returns to IDLE and drops any partial window
//   spike       in            spike train (level); a held-high pulse counts once
//   window      in  [WIN_W]   window length minus one, sampled only at window start
//   rate        out [WIN_W]   spike count of the last completed window
//   rate_valid  out           one-cycle pulse, rate just updated
//   isi         out [ISI_W]   cycles between the last two rising edges (saturating)
//   isi_valid   out           one-cycle pulse, isi just updated
//   isi_sat     out           last isi value saturated
//   busy        out           high while counting
module spike_rate_decoder #(
   parameter int unsigned WIN_W = 8,
   parameter int unsigned ISI_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             spike,
   input  logic [WIN_W-1:0] window,
   output logic [WIN_W-1:0] rate,
   output logic             rate_valid,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid,
   output logic             isi_sat,
   output logic             busy
);

   localparam logic StIdle  = 1'b0;
   localparam logic StCount = 1'b1;

   localparam logic [ISI_W-1:0] IsiMax   = '1;
   // since+1 reaches IsiMax once since is IsiMax-1 or more
   localparam logic [ISI_W-1:0] IsiMaxM1 = {{(ISI_W-1){1'b1}}, 1'b0};

   logic             state_q, state_d;
   logic             prev_spike_q;
   logic [WIN_W-1:0] win_len_q, win_len_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [WIN_W-1:0] spk_cnt_q, spk_cnt_d;
   logic [ISI_W-1:0] since_q, since_d;
   logic             have_ref_q, have_ref_d;
   logic [WIN_W-1:0] rate_q, rate_d;
   logic             rate_valid_q, rate_valid_d;
   logic [ISI_W-1:0] isi_q, isi_d;
   logic             isi_valid_q, isi_valid_d;
   logic             isi_sat_q, isi_sat_d;

   logic spike_edge;
   logic since_at_sat;

   assign spike_edge   = spike & ~prev_spike_q;
   assign since_at_sat = (since_q >= IsiMaxM1);

   always_comb begin
      state_d      = state_q;
      win_len_d    = win_len_q;
      win_cnt_d    = win_cnt_q;
      spk_cnt_d    = spk_cnt_q;
      since_d      = since_q;
      have_ref_d   = have_ref_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      isi_d        = isi_q;
      isi_valid_d  = 1'b0;
      isi_sat_d    = isi_sat_q;

      if (state_q == StIdle) begin
         if (en) begin
            // Edges in the entry cycle are deliberately ignored
            state_d    = StCount;
            win_len_d  = window;
            win_cnt_d  = '0;
            spk_cnt_d  = '0;
            since_d    = '0;
            have_ref_d = 1'b0;
         end
      end else begin
         if (!en) begin
            // Abort: partial window dropped, rate held
            state_d    = StIdle;
            have_ref_d = 1'b0;
         end else begin
            if (win_cnt_q == win_len_q) begin
               // Close and restart back-to-back, re-latching the length
               rate_d       = spk_cnt_q + WIN_W'(spike_edge);
               rate_valid_d = 1'b1;
               win_cnt_d    = '0;
               spk_cnt_d    = '0;
               win_len_d    = window;
            end else begin
               spk_cnt_d = spk_cnt_q + WIN_W'(spike_edge);
               win_cnt_d = win_cnt_q + WIN_W'(1);
            end

            if (spike_edge) begin
               since_d    = '0;
               have_ref_d = 1'b1;
               // First edge after entry only arms the reference
               if (have_ref_q) begin
                  isi_d       = since_at_sat ? IsiMax : (since_q + ISI_W'(1));
                  isi_sat_d   = since_at_sat;
                  isi_valid_d = 1'b1;
               end
            end else if (since_q != IsiMax) begin
               since_d = since_q + ISI_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         prev_spike_q <= 1'b0;
         win_len_q    <= '0;
         win_cnt_q    <= '0;
         spk_cnt_q    <= '0;
         since_q      <= '0;
         have_ref_q   <= 1'b0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
         isi_q        <= '0;
         isi_valid_q  <= 1'b0;
         isi_sat_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_spike_q <= spike;
         win_len_q    <= win_len_d;
         win_cnt_q    <= win_cnt_d;
         spk_cnt_q    <= spk_cnt_d;
         since_q      <= since_d;
         have_ref_q   <= have_ref_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
         isi_q        <= isi_d;
         isi_valid_q  <= isi_valid_d;
         isi_sat_q    <= isi_sat_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = rate_valid_q;
   assign isi        = isi_q;
   assign isi_valid  = isi_valid_q;
   assign isi_sat    = isi_sat_q;
   assign busy       = (state_q == StCount);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: stimulus pushes hand-computed
// rate/isi results with the clock edge they should follow; the monitor pops
// and compares whenever rate_valid or isi_valid is seen.
module tb_spike_rate_decoder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       spike;
   logic [7:0] window;
   logic [7:0] rate;
   logic       rate_valid;
   logic [7:0] isi;
   logic       isi_valid;
   logic       isi_sat;
   logic       busy;

   spike_rate_decoder #(
      .WIN_W(8),
      .ISI_W(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .spike      (spike),
      .window     (window),
      .rate       (rate),
      .rate_valid (rate_valid),
      .isi        (isi),
      .isi_valid  (isi_valid),
      .isi_sat    (isi_sat),
      .busy       (busy)
   );

   typedef struct {
      int val;
      int sat;
      int edge_i;
   } exp_t;

   exp_t rate_q[$];
   exp_t isi_q[$];
   exp_t mon_r;
   exp_t mon_i;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
      end
   endfunction

   // Drive one clock: inputs apply to the next rising edge; optional expectations
   // (negative = none) are tied to that edge.
   task automatic tick(input logic e, input logic s, input logic [7:0] w,
                       input int er, input int ei, input int es);
      exp_t x;
      en     = e;
      spike  = s;
      window = w;
      if (er >= 0) begin
         x.val = er; x.sat = 0; x.edge_i = cyc + 1;
         rate_q.push_back(x);
      end
      if (ei >= 0) begin
         x.val = ei; x.sat = es; x.edge_i = cyc + 1;
         isi_q.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (rate_valid) begin
            if (rate_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rate_valid: unexpected pulse at edge %0d, rate=%0d, expected none",
                        cyc, rate);
            end else begin
               mon_r = rate_q.pop_front();
               check("rate_value", int'(rate), mon_r.val);
               check("rate_timing", cyc, mon_r.edge_i);
            end
         end
         if (isi_valid) begin
            if (isi_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL isi_valid: unexpected pulse at edge %0d, isi=%0d, expected none",
                        cyc, isi);
            end else begin
               mon_i = isi_q.pop_front();
               check("isi_value", int'(isi), mon_i.val);
               check("isi_sat", int'(isi_sat), mon_i.sat);
               check("isi_timing", cyc, mon_i.edge_i);
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      spike  = 1'b0;
      window = 8'd9;
      #12;
      // Reset state
      check("rst_rate", int'(rate), 0);
      check("rst_rate_valid", int'(rate_valid), 0);
      check("rst_isi", int'(isi), 0);
      check("rst_isi_valid", int'(isi_valid), 0);
      check("rst_isi_sat", int'(isi_sat), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (2) tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      check("idle_busy", int'(busy), 0);

      // Basic rate: alternating spikes from the first COUNT cycle, 3 windows of 10
      tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      check("count_busy", int'(busy), 1);
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, (i % 2 == 0), 8'd9, (i % 10 == 9) ? 5 : -1,
              (i >= 2 && i % 2 == 0) ? 2 : -1, 0);
      end
      repeat (3) tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      check("pre_reset_rate", int'(rate), 5);

      // Asynchronous reset mid-COUNT
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rate", int'(rate), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_isi", int'(isi), 0);
      en = 1'b0;
      repeat (2) tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      check("post_rst_busy", int'(busy), 0);

      // Held level: high for a whole window counts once, then zero
      tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b1, 8'd9, (i == 9) ? 1 : ((i == 19) ? 0 : -1), -1, 0);
      end
      tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      check("held_idle_busy", int'(busy), 0);

      // ISI: edges at COUNT cycles 3, 10, 12
      tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, (i == 3 || i == 10 || i == 12), 8'd9,
              (i == 9) ? 1 : ((i == 19) ? 2 : -1),
              (i == 10) ? 7 : ((i == 12) ? 2 : -1), 0);
      end
      tick(1'b0, 1'b0, 8'd9, -1, -1, 0);

      // ISI saturation: edges at 0, 300 (saturates) and 554 (254 apart, just below)
      tick(1'b1, 1'b0, 8'd255, -1, -1, 0);
      for (int i = 0; i < 555; i++) begin
         tick(1'b1, (i == 0 || i == 300 || i == 554), 8'd255,
              (i == 255 || i == 511) ? 1 : -1,
              (i == 300) ? 255 : ((i == 554) ? 254 : -1),
              (i == 300) ? 1 : 0);
      end
      tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      check("sat_idle_rate", int'(rate), 1);

      // Abort at win_cnt=4: no rate_valid, rate held, busy drops
      tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      for (int i = 0; i < 4; i++) tick(1'b1, (i == 1), 8'd9, -1, -1, 0);
      tick(1'b0, 1'b0, 8'd9, -1, -1, 0);
      check("abort_busy", int'(busy), 0);
      check("abort_rate_held", int'(rate), 1);
      repeat (2) tick(1'b0, 1'b0, 8'd9, -1, -1, 0);

      // Re-latch: window 9 -> 3 mid-window; current window stays 10, then 4-cycle windows
      tick(1'b1, 1'b0, 8'd9, -1, -1, 0);
      for (int i = 0; i < 18; i++) begin
         tick(1'b1, (i == 1 || i == 5 || i == 8 || i == 11 || i == 13 || i == 15),
              (i < 2) ? 8'd9 : 8'd3,
              (i == 9) ? 3 : ((i == 13) ? 2 : ((i == 17) ? 1 : -1)),
              (i == 5) ? 4 : ((i == 8 || i == 11) ? 3 : ((i == 13 || i == 15) ? 2 : -1)), 0);
      end
      tick(1'b0, 1'b0, 8'd3, -1, -1, 0);
      repeat (3) tick(1'b0, 1'b0, 8'd3, -1, -1, 0);

      // Every expected pulse must have been seen
      check("rate_queue_drained", rate_q.size(), 0);
      check("isi_queue_drained", isi_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the LIF neuron: converts a 1-bit spike train back into numeric values.
- Reports a rate value: rising-edge spike count over a programmable window of clock cycles.
- Reports a timing value: the last inter-spike interval (ISI).
- Sits downstream of the neuron's spike output, or on a pin fed from another tile, and drives results onto the 8-bit output/bidirectional buses.

Parameters:
- WIN_W, 8, width of window length, spike count and rate output; window length range 1..2^WIN_W cycles.
- ISI_W, 8, width of ISI counter and output; saturates at 2^ISI_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  decoder enable; low forces IDLE
- spike  in  1  spike train, level signal, may stay high several cycles
- window  in  WIN_W  window length minus one; sampled only at window start
- rate  out  WIN_W  spike count of last completed window
- rate_valid  out  1  one-cycle pulse, rate just updated
- isi  out  ISI_W  cycles between last two rising edges
- isi_valid  out  1  one-cycle pulse, isi just updated
- isi_sat  out  1  last isi value saturated
- busy  out  1  high while in COUNT

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rate=0, rate_valid=0, isi=0, isi_valid=0, isi_sat=0, busy=0.
  - State IDLE; internal counters 0; prev_spike=0; have_ref=0.
- Edge detect:
  - prev_spike <= spike every cycle, in every state.
  - edge = spike & ~prev_spike, combinational in the cycle spike first reads high.
  - A held-high spike counts once.
- States:
  - IDLE → COUNT: on a clock edge with en=1.
    - win_len <= window; win_cnt <= 0; spk_cnt <= 0; have_ref <= 0.
    - An edge in this cycle is not counted.
  - COUNT: each cycle, spk_cnt <= spk_cnt + edge; win_cnt <= win_cnt + 1.
    - Window covers cycles win_cnt = 0..win_len, i.e. win_len+1 cycles.
    - Max count is 2^(WIN_W-1), so no count overflow is possible.
  - Window close: in the COUNT cycle with win_cnt == win_len and en=1.
    - rate <= spk_cnt + edge; rate_valid <= 1 in the next cycle only.
    - Next window starts back-to-back with no gap cycle: win_cnt <= 0, spk_cnt <= 0, win_len <= window (re-latched).
  - COUNT → IDLE: on any cycle with en=0.
    - Partial window discarded; rate is held; no rate_valid.
    - have_ref <= 0.
    - If en falls in the closing cycle, the window is discarded.
- ISI (COUNT only):
  - since counts cycles since the last counted edge, saturating at 2^ISI_W-1.
  - On an edge with have_ref=1: isi <= min(since+1, 2^ISI_W-1); isi_sat <= (since+1 >= 2^ISI_W-1); isi_valid pulse next cycle.
  - Any edge: since <= 0, have_ref <= 1.
  - The first edge after entering COUNT only arms the reference and does not update isi.
  - ISI tracking is continuous across window boundaries.
- Output timing:
  - rate_valid and isi_valid are registered: high exactly 1 cycle, the cycle after the triggering clock edge.
  - They may pulse in the same cycle.
- busy = (state == COUNT).
- window changes mid-window have no effect until the next window start.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-COUNT with rate=5 → all outputs 0 immediately, before the next clk edge; after release with en=0, busy stays 0.
- Basic rate: window=9, en=1, spike pattern 1,0,1,0… aligned to first COUNT cycle → rate_valid pulses every 10 cycles, rate=5 each window.
- Held level: window=9, spike held high for all 10 cycles of a window after a 0 in the cycle before the window → rate=1; following window with spike still high → rate=0.
- ISI: rising edges at COUNT cycles 3, 10, 12 → no isi_valid at cycle 3; isi=7 after cycle 10; isi=2 after cycle 12; isi_sat=0.
- ISI saturation (ISI_W=8): edges 300 cycles apart → isi=255, isi_sat=1.
- Abort/re-latch: en low at win_cnt=4 → no rate_valid, rate unchanged, busy=0 next cycle. window changed 9→3 mid-window → current window still 10 cycles, next windows 4 cycles.
